// File: rtl/dmem_bus_bridge.sv
// dmem_bus_bridge: CPU data port to req/ack bus bridge with posted 1-entry write buffer and read timeout
module dmem_bus_bridge #(
    parameter int          TIMEOUT  = 255,
    parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dce,
    input  logic [31:0] daddr,
    input  logic [3:0]  we,
    input  logic [31:0] din,
    output logic [31:0] dm,
    output logic        stall,
    output logic        bus_req,
    output logic        bus_wr,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic        bus_err
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, WR, RD, WR_RD} state_t;

    state_t        state_q, state_d;
    logic [31:0]   dm_q, dm_d, addr_q, addr_d, wdata_q, wdata_d, raddr_q, raddr_d;
    logic [3:0]    be_q, be_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          rd, wr, busy, tmo, done, take, ld;
    logic [31:0]   waddr;

    assign rd    = dce & (we == 4'b0000);
    assign wr    = dce & (|we);
    assign waddr = daddr & ~32'h3;
    assign busy  = state_q != IDLE;
    assign tmo   = busy & (cnt_q == CW'(TIMEOUT));
    assign done  = busy & (bus_ack | tmo);
    // the bus is free for a new CPU access when idle or when the buffered write finishes now
    assign take  = (state_q == IDLE) | ((state_q == WR) & done);

    assign bus_req   = busy & ~tmo;
    assign bus_wr    = (state_q == WR) | (state_q == WR_RD);
    assign bus_err   = tmo & ~bus_ack;
    assign dm        = dm_q;
    assign bus_addr  = addr_q;
    assign bus_be    = be_q;
    assign bus_wdata = wdata_q;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        raddr_d = raddr_q;
        dm_d    = dm_q;
        stall   = 1'b0;
        ld      = 1'b0;
        if (take) begin
            stall   = rd;
            ld      = dce;
            state_d = wr ? WR : rd ? RD : IDLE;
            addr_d  = dce ? waddr : addr_q;
            be_d    = wr ? we : rd ? 4'hF : be_q;
            wdata_d = wr ? din : wdata_q;
        end else begin
            case (state_q)
                WR: begin
                    stall   = dce;
                    state_d = rd ? WR_RD : WR;
                    raddr_d = rd ? waddr : raddr_q;
                end
                WR_RD: begin
                    stall   = 1'b1;
                    ld      = done;
                    state_d = done ? RD : WR_RD;
                    addr_d  = done ? raddr_q : addr_q;
                    be_d    = done ? 4'hF : be_q;
                end
                default: begin
                    stall   = ~done;
                    state_d = done ? IDLE : RD;
                    dm_d    = !done ? dm_q : bus_ack ? bus_rdata : ERR_DATA;
                end
            endcase
        end
        cnt_d = ld ? '0 : (bus_req & ~bus_ack) ? cnt_q + CW'(1) : cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            dm_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            raddr_q <= '0;
            be_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            dm_q    <= dm_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            raddr_q <= raddr_d;
            be_q    <= be_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: tb/tb_dmem_bus_bridge.sv
// tb_dmem_bus_bridge: directed stimulus with a bus-transaction scoreboard checked by a separate monitor
module tb_dmem_bus_bridge;
    logic        clk = 1'b0, rst = 1'b1;
    logic        dce = 1'b0, bus_ack = 1'b0;
    logic [31:0] daddr = '0, din = '0, bus_rdata = '0;
    logic [3:0]  we = '0;
    logic [31:0] dm, bus_addr, bus_wdata;
    logic [3:0]  bus_be;
    logic        stall, bus_req, bus_wr, bus_err;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] data;
        logic        err;
    } txn_t;

    txn_t exp_q[$];
    int   errors = 0, checks = 0, err_pulses = 0;

    dmem_bus_bridge #(.TIMEOUT(8), .ERR_DATA(32'hDEADBEEF)) dut (
        .clk(clk), .rst(rst), .dce(dce), .daddr(daddr), .we(we), .din(din),
        .dm(dm), .stall(stall), .bus_req(bus_req), .bus_wr(bus_wr),
        .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void push(input logic w, input logic [31:0] a, input logic [3:0] b,
                                 input logic [31:0] d, input logic e);
        txn_t t;
        t.wr = w; t.addr = a; t.be = b; t.data = d; t.err = e;
        exp_q.push_back(t);
    endfunction

    task automatic cyc(input logic c, input logic [31:0] a, input logic [3:0] w,
                       input logic [31:0] d, input logic ack, input logic [31:0] rdat);
        @(posedge clk);
        #1;
        dce = c; daddr = a; we = w; din = d; bus_ack = ack; bus_rdata = rdat;
        #1;
    endtask

    // monitor: pops an expected transaction at each completion, checks dm one cycle later
    logic        dm_pend = 1'b0;
    logic [31:0] dm_exp = '0;
    always @(negedge clk) begin
        txn_t t;
        if (dm_pend) chk("dm_after_read", dm, dm_exp);
        dm_pend = 1'b0;
        if (bus_err) err_pulses++;
        if ((bus_req && bus_ack) || bus_err) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_txn", {31'b0, bus_wr}, 32'hFFFFFFFF);
            end else begin
                t = exp_q.pop_front();
                chk("txn_err", {31'b0, bus_err}, {31'b0, t.err});
                chk("txn_wr", {31'b0, bus_wr}, {31'b0, t.wr});
                chk("txn_addr", bus_addr, t.addr);
                chk("txn_be", {28'b0, bus_be}, {28'b0, t.be});
                if (t.wr) chk("txn_wdata", bus_wdata, t.data);
                else begin
                    dm_pend = 1'b1;
                    dm_exp = t.data;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        chk("rst_req", {31'b0, bus_req}, 0);
        chk("rst_stall", {31'b0, stall}, 0);
        chk("rst_dm", dm, 0);
        chk("rst_addr", bus_addr, 0);
        chk("rst_be", {28'b0, bus_be}, 0);
        chk("rst_err", {31'b0, bus_err}, 0);
        rst = 1'b0;
        // 1: posted store, acked on its second bus cycle
        cyc(1, 32'h100, 4'hF, 32'h12345678, 0, 0);
        push(1, 32'h100, 4'hF, 32'h12345678, 0);
        chk("t1_stall0", {31'b0, stall}, 0);
        cyc(0, 0, 0, 0, 0, 0);
        chk("t1_req1", {31'b0, bus_req}, 1);
        chk("t1_stall1", {31'b0, stall}, 0);
        cyc(0, 0, 0, 0, 1, 0);
        chk("t1_req2", {31'b0, bus_req}, 1);
        chk("t1_stall2", {31'b0, stall}, 0);
        cyc(0, 0, 0, 0, 0, 0);
        chk("t1_req_off", {31'b0, bus_req}, 0);
        // 2: load with zero-wait slave
        cyc(1, 32'h104, 4'h0, 0, 0, 0);
        push(0, 32'h104, 4'hF, 32'hCAFEF00D, 0);
        chk("t2_stall0", {31'b0, stall}, 1);
        cyc(1, 32'h104, 4'h0, 0, 1, 32'hCAFEF00D);
        chk("t2_req", {31'b0, bus_req}, 1);
        chk("t2_stall1", {31'b0, stall}, 0);
        cyc(0, 0, 0, 0, 0, 0);
        chk("t2_dm", dm, 32'hCAFEF00D);
        chk("t2_idle", {31'b0, bus_req}, 0);
        // 3: byte store then load behind it; read waits for write ack
        cyc(1, 32'h203, 4'b0010, 32'h0000AB00, 0, 0);
        push(1, 32'h200, 4'b0010, 32'h0000AB00, 0);
        chk("t3_stall0", {31'b0, stall}, 0);
        cyc(1, 32'h200, 4'h0, 0, 0, 0);
        push(0, 32'h200, 4'hF, 32'h11223344, 0);
        chk("t3_stall1", {31'b0, stall}, 1);
        cyc(1, 32'h200, 4'h0, 0, 0, 0);
        chk("t3_stall2", {31'b0, stall}, 1);
        chk("t3_wr2", {31'b0, bus_wr}, 1);
        cyc(1, 32'h200, 4'h0, 0, 1, 0);
        chk("t3_stall3", {31'b0, stall}, 1);
        chk("t3_be_w", {28'b0, bus_be}, 4'b0010);
        cyc(1, 32'h200, 4'h0, 0, 0, 0);
        chk("t3_rd_wr", {31'b0, bus_wr}, 0);
        chk("t3_rd_addr", bus_addr, 32'h200);
        chk("t3_stall4", {31'b0, stall}, 1);
        cyc(1, 32'h200, 4'h0, 0, 1, 32'h11223344);
        chk("t3_stall5", {31'b0, stall}, 0);
        cyc(0, 0, 0, 0, 0, 0);
        // 4: back-to-back stores, first acked in second's cycle
        cyc(1, 32'h300, 4'hF, 32'hAAAA0001, 0, 0);
        push(1, 32'h300, 4'hF, 32'hAAAA0001, 0);
        chk("t4_stall0", {31'b0, stall}, 0);
        cyc(1, 32'h304, 4'hF, 32'hBBBB0002, 1, 0);
        push(1, 32'h304, 4'hF, 32'hBBBB0002, 0);
        chk("t4_stall1", {31'b0, stall}, 0);
        chk("t4_req1", {31'b0, bus_req}, 1);
        cyc(0, 0, 0, 0, 0, 0);
        chk("t4_req2", {31'b0, bus_req}, 1);
        chk("t4_addr2", bus_addr, 32'h304);
        cyc(0, 0, 0, 0, 1, 0);
        chk("t4_req3", {31'b0, bus_req}, 1);
        cyc(0, 0, 0, 0, 0, 0);
        chk("t4_req_off", {31'b0, bus_req}, 0);
        // 5: read timeout after 8 unacked request cycles
        cyc(1, 32'h400, 4'h0, 0, 0, 0);
        push(0, 32'h400, 4'hF, 32'hDEADBEEF, 1);
        for (int i = 0; i < 8; i++) begin
            cyc(1, 32'h400, 4'h0, 0, 0, 0);
            chk("t5_req_wait", {31'b0, bus_req}, 1);
            chk("t5_stall_wait", {31'b0, stall}, 1);
            chk("t5_err_wait", {31'b0, bus_err}, 0);
        end
        cyc(1, 32'h400, 4'h0, 0, 0, 0);
        chk("t5_req_to", {31'b0, bus_req}, 0);
        chk("t5_err_to", {31'b0, bus_err}, 1);
        chk("t5_stall_to", {31'b0, stall}, 0);
        cyc(0, 0, 0, 0, 0, 0);
        chk("t5_err_after", {31'b0, bus_err}, 0);
        chk("t5_idle", {31'b0, bus_req}, 0);
        // 6: reset during outstanding read, then a stray ack
        cyc(1, 32'h500, 4'h0, 0, 0, 0);
        chk("t6_stall0", {31'b0, stall}, 1);
        cyc(0, 0, 0, 0, 0, 0);
        chk("t6_req_busy", {31'b0, bus_req}, 1);
        rst = 1'b1;
        cyc(0, 0, 0, 0, 1, 32'h55555555);
        rst = 1'b0;
        chk("t6_req_rst", {31'b0, bus_req}, 0);
        chk("t6_stall_rst", {31'b0, stall}, 0);
        chk("t6_dm_rst", dm, 0);
        cyc(0, 0, 0, 0, 0, 0);
        chk("t6_dm_stray", dm, 0);
        chk("t6_req_stray", {31'b0, bus_req}, 0);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        chk("queue_empty", exp_q.size(), 0);
        chk("err_pulses", err_pulses, 1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
